// File: rtl/conv1d_window_stream_buffer.sv
// rtl/conv1d_window_stream_buffer.sv - row buffer streaming Kernel_Size-wide sliding windows
module conv1d_window_stream_buffer #(
    parameter int Bit_width   = 16,
    parameter int RAM_Depth   = 512,
    parameter int Addr_width  = 9,
    parameter int Kernel_Size = 5
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             Write_Enable,
    input  logic [Addr_width-1:0]            Write_Addr,
    input  logic [Bit_width-1:0]             data_in,
    output logic                             Write_Err,
    input  logic                             Start,
    input  logic [Addr_width:0]              Length,
    input  logic [1:0]                       Stride,
    input  logic                             Pad_Mode,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [Kernel_Size*Bit_width-1:0] data_out,
    output logic [Addr_width-1:0]            center_idx,
    output logic                             busy,
    output logic                             done
);
    localparam int Half = (Kernel_Size - 1) / 2;
    // Signed tap index: holds c - Half .. c + Half with c up to RAM_Depth + Stride.
    localparam int CW = Addr_width + 3;
    localparam logic [Addr_width:0] DEPTH_L = (Addr_width + 1)'(RAM_Depth);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

    state_t                state, state_nx;
    logic [Addr_width:0]   len_lat;
    logic [Addr_width:0]   len_clamped;
    logic [1:0]            stride_lat;
    logic [1:0]            stride_eff;
    logic                  pad_lat;
    logic [Addr_width+1:0] c;
    logic [Addr_width+1:0] c_step;
    logic                  advance;
    logic                  issue;
    logic                  wr_en;

    assign len_clamped = (Length > DEPTH_L) ? DEPTH_L : Length;
    assign stride_eff  = (Stride == 2'd0) ? 2'd1 : Stride;
    // A read may only be issued when the output register is free or being emptied,
    // so the RAM output register itself acts as the hold stage under backpressure.
    assign advance     = !out_valid || out_ready;
    assign issue       = (state == STREAM) && advance;
    assign c_step      = c + {{Addr_width{1'b0}}, stride_lat};
    assign wr_en       = Write_Enable && (state == IDLE);
    assign busy        = (state != IDLE);

    // Next-state logic for the row sequencer.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (Start) state_nx = (len_clamped == '0) ? FINISH : STREAM;
            STREAM: if (issue && (c_step >= {1'b0, len_lat})) state_nx = DRAIN;
            DRAIN:  if (advance) state_nx = FINISH;
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register plus per-row latched configuration and centre counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            len_lat    <= '0;
            stride_lat <= 2'd1;
            pad_lat    <= 1'b0;
            c          <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && Start) begin
                len_lat    <= len_clamped;
                stride_lat <= stride_eff;
                pad_lat    <= Pad_Mode;
                c          <= '0;
            end else if (issue) begin
                c <= c_step;
            end
        end
    end

    // Output handshake, centre tag, done and write-error pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid  <= 1'b0;
            center_idx <= '0;
            done       <= 1'b0;
            Write_Err  <= 1'b0;
        end else begin
            if (issue) begin
                out_valid  <= 1'b1;
                center_idx <= c[Addr_width-1:0];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            done      <= (state == FINISH);
            Write_Err <= Write_Enable && (state != IDLE);
        end
    end

    for (genvar k = 0; k < Kernel_Size; k++) begin : g_bank
        localparam logic signed [CW-1:0] OFF = CW'(k - Half);

        logic [Bit_width-1:0]  mem [RAM_Depth];
        logic [Bit_width-1:0]  q;
        logic signed [CW-1:0]  idx;
        logic                  lo;
        logic                  hi;
        logic                  pad_zero;
        logic [Addr_width-1:0] rd_addr;

        assign idx = $signed({1'b0, c}) + OFF;
        assign lo  = (idx < 0);
        assign hi  = (idx >= $signed({2'b00, len_lat}));
        // Out-of-range taps read the nearest edge; zero padding then masks the value.
        assign rd_addr = lo ? '0 : (hi ? Addr_width'(len_lat - 1'b1) : idx[Addr_width-1:0]);

        // Replicated bank: identical writes, one synchronous read per issued window.
        always_ff @(posedge CLK) begin
            if (wr_en) mem[Write_Addr] <= data_in;
            if (issue) q <= mem[rd_addr];
        end

        // Zero-pad mask travels with the read; it resets high so data_out starts at 0.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N)     pad_zero <= 1'b1;
            else if (issue) pad_zero <= (lo || hi) && !pad_lat;
        end

        assign data_out[k*Bit_width +: Bit_width] = pad_zero ? '0 : q;
    end
endmodule

// File: tb/tb_conv1d_window_stream_buffer.sv
// tb/tb_conv1d_window_stream_buffer.sv - scoreboard bench for conv1d_window_stream_buffer
module tb_conv1d_window_stream_buffer;
    localparam int W  = 16;
    localparam int K  = 5;
    localparam int D  = 512;
    localparam int AW = 9;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           we = 1'b0;
    logic [AW-1:0]  waddr = '0;
    logic [W-1:0]   wdata = '0;
    logic           werr;
    logic           start = 1'b0;
    logic [AW:0]    length = '0;
    logic [1:0]     stride = '0;
    logic           pad = 1'b0;
    logic           ov;
    logic           ordy = 1'b0;
    logic [K*W-1:0] dout;
    logic [AW-1:0]  cidx;
    logic           busy;
    logic           done;

    conv1d_window_stream_buffer #(
        .Bit_width(W), .RAM_Depth(D), .Addr_width(AW), .Kernel_Size(K)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .Write_Enable(we), .Write_Addr(waddr),
        .data_in(wdata), .Write_Err(werr), .Start(start), .Length(length),
        .Stride(stride), .Pad_Mode(pad), .out_valid(ov), .out_ready(ordy),
        .data_out(dout), .center_idx(cidx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [K*W-1:0] exp_d[$];
    int             exp_c[$];
    int             ram_m[D];
    bit             rdy_tab[6] = '{1, 0, 0, 1, 0, 1};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic [K*W-1:0] pack5(input int t0, input int t1, input int t2,
                                             input int t3, input int t4);
        logic [K*W-1:0] r;
        r = {W'(t4), W'(t3), W'(t2), W'(t1), W'(t0)};
        return r;
    endfunction

    task automatic push(input int c, input logic [K*W-1:0] d);
        exp_c.push_back(c);
        exp_d.push_back(d);
    endtask

    function automatic int model_tap(input int idx, input int len, input bit p);
        if (idx >= 0 && idx < len) return ram_m[idx];
        if (!p) return 0;
        return (idx < 0) ? ram_m[0] : ram_m[len-1];
    endfunction

    task automatic push_model(input int len, input int s, input bit p);
        int le;
        int se;
        le = (len > D) ? D : len;
        se = (s == 0) ? 1 : s;
        for (int c = 0; c < le; c += se)
            push(c, pack5(model_tap(c-2, le, p), model_tap(c-1, le, p), model_tap(c, le, p),
                          model_tap(c+1, le, p), model_tap(c+2, le, p)));
    endtask

    task automatic push_zero8();
        push(0, pack5(0, 0, 1, 2, 3));
        push(1, pack5(0, 1, 2, 3, 4));
        push(2, pack5(1, 2, 3, 4, 5));
        push(3, pack5(2, 3, 4, 5, 6));
        push(4, pack5(3, 4, 5, 6, 7));
        push(5, pack5(4, 5, 6, 7, 8));
        push(6, pack5(5, 6, 7, 8, 0));
        push(7, pack5(6, 7, 8, 0, 0));
    endtask

    // Monitor: pops one expectation per transfer and checks stall stability.
    logic [K*W-1:0] held_d;
    logic [AW-1:0]  held_c;
    bit             prev_stall = 0;
    int             ec;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", ov, 1);
                chk("stall_data", dout, held_d);
                chk("stall_center", cidx, held_c);
            end
            prev_stall = ov && !ordy;
            held_d = dout;
            held_c = cidx;
            if (ov && ordy) begin
                if (exp_c.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_window: actual center %0d required none", cidx);
                end else begin
                    ec = exp_c.pop_front();
                    chk("center", cidx, ec);
                    chk("window", dout, exp_d.pop_front());
                end
            end
        end
    end

    task automatic run(input int len, input int s, input bit p, input bit bp, input int wr_at,
                       input int rst_after, input int exp_n, input string tag);
        int n;
        int first_v;
        int last_x;
        int done_n;
        int xf;
        int bound;
        bit got;
        n = 0; first_v = -1; last_x = -1; done_n = -1; xf = 0; got = 0;
        bound = 4 * ((len > D) ? D : len) + 40;
        @(posedge clk); #1;
        length = len[AW:0];
        stride = s[1:0];
        pad    = p;
        start  = 1'b1;
        ordy   = bp ? rdy_tab[0] : 1'b1;
        while (!got && n < bound) begin
            @(negedge clk);
            if (ov && first_v < 0) first_v = n;
            if (ov && ordy) begin last_x = n; xf++; end
            if (done) begin got = 1; done_n = n; end
            if (wr_at > 0 && n == wr_at + 1) chk({tag, " write_err"}, werr, 1);
            if (rst_after > 0 && xf == rst_after) begin
                #2 rst_n = 1'b0;
                #1;
                chk({tag, " valid_after_reset"}, ov, 0);
                chk({tag, " busy_after_reset"}, busy, 0);
                chk({tag, " center_after_reset"}, cidx, 0);
                chk({tag, " data_after_reset"}, dout, 0);
                chk({tag, " queue_at_reset"}, exp_c.size(), 0);
                repeat (2) begin
                    @(negedge clk);
                    chk({tag, " no_done_in_reset"}, done, 0);
                end
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            we    = 1'b0;
            n++;
            ordy = bp ? rdy_tab[n % 6] : 1'b1;
            if (wr_at > 0 && n == wr_at) begin
                we = 1'b1; waddr = 3; wdata = 16'h7FFF;
            end
        end
        chk({tag, " done_seen"}, got, 1);
        chk({tag, " windows"}, xf, exp_n);
        chk({tag, " queue_empty"}, exp_c.size(), 0);
        if (exp_n > 0) begin
            chk({tag, " first_valid_latency"}, first_v, 2);
            chk({tag, " done_after_last"}, done_n - last_x, 2);
        end else begin
            chk({tag, " no_valid"}, first_v, -1);
            chk({tag, " done_latency"}, done_n, 2);
        end
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done, 0);
        ordy = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset out_valid", ov, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset write_err", werr, 0);
        chk("reset center_idx", cidx, 0);
        chk("reset data_out", dout, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < D; i++) begin
            @(posedge clk); #1;
            we = 1'b1; waddr = i[AW-1:0]; wdata = W'(i + 1);
            ram_m[i] = i + 1;
        end
        @(posedge clk); #1;
        we = 1'b0;

        push_zero8();
        run(8, 1, 0, 0, 0, 0, 8, "zero_l8");

        push(0, pack5(1, 1, 1, 2, 3));
        push(1, pack5(1, 1, 2, 3, 4));
        push(2, pack5(1, 2, 3, 4, 5));
        push(3, pack5(2, 3, 4, 5, 6));
        push(4, pack5(3, 4, 5, 6, 7));
        push(5, pack5(4, 5, 6, 7, 8));
        push(6, pack5(5, 6, 7, 8, 8));
        push(7, pack5(6, 7, 8, 8, 8));
        run(8, 1, 1, 0, 0, 0, 8, "rep_l8");

        push(0, pack5(0, 0, 1, 2, 3));
        push(2, pack5(1, 2, 3, 4, 5));
        push(4, pack5(3, 4, 5, 6, 7));
        push(6, pack5(5, 6, 7, 0, 0));
        run(7, 2, 0, 0, 0, 0, 4, "stride2_l7");

        push_zero8();
        run(8, 0, 0, 0, 0, 0, 8, "stride0_l8");

        push_model(16, 1, 0);
        run(16, 1, 0, 1, 3, 0, 16, "backpressure_l16");

        push_model(16, 1, 0);
        run(16, 1, 0, 0, 0, 0, 16, "after_dropped_write");

        run(0, 1, 0, 0, 0, 0, 0, "len0");

        push_model(600, 1, 0);
        run(600, 1, 0, 0, 0, 0, 512, "len600");

        push_model(10, 1, 0);
        while (exp_c.size() > 4) begin
            void'(exp_c.pop_back());
            void'(exp_d.pop_back());
        end
        run(10, 1, 0, 0, 0, 4, 4, "reset_mid");

        push_model(10, 1, 1);
        run(10, 1, 1, 0, 0, 0, 10, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv1d_window_stream_buffer.md
Name: conv1d_window_stream_buffer

Overview:
- Parametrised successor to the fixed 5-tap first-layer CONV1D data RAM.
- Stores one input feature row and streams Kernel_Size-wide sliding windows to the MAC array under valid/ready flow control.
- Adds a run-time length, selectable stride, zero or edge-replicate padding, and an FSM-driven sequencer, so the conv controller issues one Start per row instead of per-tap addresses.

Parameters:
- Bit_width, 16, sample width (signed two's complement).
- RAM_Depth, 512, samples per row; power of two.
- Addr_width, 9, log2(RAM_Depth).
- Kernel_Size, 5, taps per window; odd, 3..9; Half = (Kernel_Size-1)/2.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Write_Enable  in  1  write strobe.
- Write_Addr  in  Addr_width  write address.
- data_in  in  Bit_width  write data.
- Write_Err  out  1  one-cycle pulse: write dropped because busy.
- Start  in  1  begin streaming one row; sampled only in IDLE.
- Length  in  Addr_width+1  valid samples in row, 0..RAM_Depth.
- Stride  in  2  window step, 1..3; 0 is treated as 1.
- Pad_Mode  in  1  0 = zero pad, 1 = replicate edge sample.
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts window.
- data_out  out  Kernel_Size*Bit_width  tap k at bits [k*Bit_width +: Bit_width]; tap k = sample[c-Half+k].
- center_idx  out  Addr_width  centre index c of the current window.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Reset values: out_valid, busy, done, Write_Err, center_idx and data_out are all 0; FSM = IDLE. RAM contents are not reset and are retained across reset.
- FSM states: IDLE, STREAM, DRAIN, FINISH.
  - IDLE: Start=1 latches Length (clamped to RAM_Depth), Stride and Pad_Mode, sets c=0, and moves to STREAM. If Length=0, moves directly to FINISH.
  - STREAM: issues a read for centre c every cycle the pipeline can advance; c += Stride. When the next c would be >= Length_lat, moves to DRAIN.
  - DRAIN: waits until every issued window has been accepted, then moves to FINISH.
  - FINISH: done=1 for one cycle, then IDLE.
- Window count = ceil(Length_lat / Stride_eff). Centres are 0, S, 2S, ... < Length_lat.
- Padding uses Length_lat, not RAM_Depth.
  - An index < 0 or >= Length_lat reads as 0 when Pad_Mode=0.
  - With Pad_Mode=1, an index < 0 reads sample[0] and an index >= Length_lat reads sample[Length_lat-1].
- Latency: with out_ready held high, the first out_valid is seen on the 2nd rising edge after the edge that samples Start. Throughput is then one window per cycle.
- Handshake:
  - A transfer happens when out_valid && out_ready.
  - While out_valid && !out_ready, data_out and center_idx stay stable.
  - out_valid never drops without a transfer.
  - The registered RAM read needs a skid or hold stage so no window is lost or duplicated under any out_ready pattern.
- Storage: Kernel_Size replicated block-RAM banks, all written identically; bank k is read at c-Half+k. Reads are synchronous, one cycle.
- Writes:
  - Accepted only in IDLE. Writes in any other state are dropped, and Write_Err pulses for one cycle.
  - A write and a Start in the same IDLE cycle: the write completes first and is visible to the stream.
- Start while busy is ignored.
- Reset mid-stream returns the FSM to IDLE immediately, with outputs as listed above. done is not emitted.
- Stride and Pad_Mode changes during a stream have no effect until the next Start.

Test Plan:
- Zero pad, K=5, Length=8, Stride=1, RAM[i]=i+1, out_ready=1 -> 8 windows, one per cycle, first valid at Start+2. Window c=0 = {0,0,1,2,3}; c=7 = {6,7,8,0,0}; done one cycle after the last transfer.
- Replicate pad, same data -> c=0 = {1,1,1,2,3}; c=7 = {6,7,8,8,8}.
- Stride=2, Length=7 -> 4 windows, centres 0,2,4,6; c=6 = {5,6,7,0,0}. Stride=0 behaves as Stride=1.
- Backpressure: out_ready toggled 1,0,0,1,0,1 ... across a Length=16 stream -> exactly 16 transfers with centres 0..15 in order, no duplicates, and data_out stable during stalls.
- Write during busy to addr 3 with value 0x7FFF -> Write_Err pulses and RAM[3] is unchanged on the next stream. Length=0 -> done at Start+2 with no out_valid. Length=600 -> clamped to 512 windows.
- RST_N asserted at window 4 of 10 -> out_valid and busy drop to 0 asynchronously with no done. A new Start then streams from c=0 with the RAM data intact.
